easyobv_axis_stats_mc: RTL

Multi-channel passive AXI4-Stream statistics monitor. It taps one AXIS link, demultiplexes beats by tdest into NUM_CH independent channel statistic sets, and counts over a start/stop or fixed-cycle measurement window. Results are read back through an indexed, registered readout port. It sits beside the traffic generator/monitor pair, on either the TX or the RX side, and provides per-destination throughput and packet-length statistics.

---
 rtl/easyobv_axis_stats_mc.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/easyobv_axis_stats_mc.sv
// Passive multi-channel AXI4-Stream statistics monitor: per-tdest packet, beat and byte
// counts plus packet-length range, gathered over a start/stop or fixed-length window.
module easyobv_axis_stats_mc #(
   parameter int DWIDTH     = 32,
   parameter int NUM_CH     = 4,
   parameter int DEST_WIDTH = 2,
   parameter int HAS_READY  = 1,
   parameter int HAS_KEEP   = 1,
   parameter int HAS_LAST   = 1,
   parameter int CNT_WIDTH  = 48,
   parameter int LEN_WIDTH  = 16,
   localparam int KW        = DWIDTH / 8,
   localparam int RD_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mon_tvalid,
   input  logic                  mon_tready,
   input  logic [KW-1:0]         mon_tkeep,
   input  logic                  mon_tlast,
   input  logic [DEST_WIDTH-1:0] mon_tdest,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  clear,
   input  logic [31:0]           window_cycles,
   input  logic [RD_W-1:0]       rd_ch,
   output logic [CNT_WIDTH-1:0]  rd_pkt_cnt,
   output logic [CNT_WIDTH-1:0]  rd_beat_cnt,
   output logic [CNT_WIDTH-1:0]  rd_byte_cnt,
   output logic [LEN_WIDTH-1:0]  rd_min_len,
   output logic [LEN_WIDTH-1:0]  rd_max_len,
   output logic [CNT_WIDTH-1:0]  unmapped_cnt,
   output logic [CNT_WIDTH-1:0]  elapsed_cnt,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam bit NO_READY = (HAS_READY == 0);
   localparam bit NO_LAST  = (HAS_LAST == 0);

   function automatic logic [CNT_WIDTH-1:0] popcount(input logic [KW-1:0] k);
      logic [CNT_WIDTH-1:0] n;
      n = '0;
      for (int j = 0; j < KW; j++) n = n + CNT_WIDTH'(k[j]);
      return n;
   endfunction

   function automatic logic [LEN_WIDTH-1:0] sat_inc(input logic [LEN_WIDTH-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   state_t               state_q, state_d;
   logic [31:0]          win_q, win_d, win_cnt_q, win_cnt_d;
   logic [CNT_WIDTH-1:0] elapsed_q, elapsed_d, unmapped_q, unmapped_d;
   logic [CNT_WIDTH-1:0] pkt_q [NUM_CH], pkt_d [NUM_CH];
   logic [CNT_WIDTH-1:0] beat_q [NUM_CH], beat_d [NUM_CH];
   logic [CNT_WIDTH-1:0] byte_q [NUM_CH], byte_d [NUM_CH];
   logic [LEN_WIDTH-1:0] min_len_q [NUM_CH], min_len_d [NUM_CH];
   logic [LEN_WIDTH-1:0] max_len_q [NUM_CH], max_len_d [NUM_CH];
   logic [LEN_WIDTH-1:0] cur_len_q [NUM_CH], cur_len_d [NUM_CH];
   logic [NUM_CH-1:0]    open_q, open_d, first_run_q, first_run_d;
   logic [CNT_WIDTH-1:0] rd_pkt_q, rd_pkt_d, rd_beat_q, rd_beat_d, rd_byte_q, rd_byte_d;
   logic [LEN_WIDTH-1:0] rd_min_q, rd_min_d, rd_max_q, rd_max_d;

   logic                 acc, running, mapped, beat_last, hit, pkt_first;
   logic [CNT_WIDTH-1:0] beat_bytes;
   logic [LEN_WIDTH-1:0] nxt_len;

   always_comb begin
      state_d     = state_q;
      win_d       = win_q;
      win_cnt_d   = win_cnt_q;
      elapsed_d   = elapsed_q;
      unmapped_d  = unmapped_q;
      pkt_d       = pkt_q;
      beat_d      = beat_q;
      byte_d      = byte_q;
      min_len_d   = min_len_q;
      max_len_d   = max_len_q;
      cur_len_d   = cur_len_q;
      open_d      = open_q;
      first_run_d = first_run_q;
      hit         = 1'b0;
      pkt_first   = 1'b0;
      nxt_len     = '0;

      acc        = mon_tvalid & (mon_tready | NO_READY);
      beat_bytes = (HAS_KEEP != 0) ? popcount(mon_tkeep) : CNT_WIDTH'(KW);
      beat_last  = mon_tlast | NO_LAST;
      running    = (state_q == S_RUN);
      mapped     = 32'(mon_tdest) < NUM_CH;

      // Packet framing is followed in every state; only RUN updates the statistics.
      for (int i = 0; i < NUM_CH; i++) begin
         hit       = acc & (32'(mon_tdest) == i);
         nxt_len   = open_q[i] ? sat_inc(cur_len_q[i]) : LEN_WIDTH'(1);
         pkt_first = open_q[i] ? first_run_q[i] : running;
         if (hit) begin
            open_d[i]      = ~beat_last;
            cur_len_d[i]   = beat_last ? '0 : nxt_len;
            first_run_d[i] = beat_last ? 1'b0 : pkt_first;
            if (running) begin
               beat_d[i] = beat_q[i] + 1'b1;
               byte_d[i] = byte_q[i] + beat_bytes;
               if (beat_last && pkt_first) begin
                  pkt_d[i] = pkt_q[i] + 1'b1;
                  if (nxt_len < min_len_q[i]) min_len_d[i] = nxt_len;
                  if (nxt_len > max_len_q[i]) max_len_d[i] = nxt_len;
               end
            end
         end
      end
      if (running && acc && !mapped) unmapped_d = unmapped_q + 1'b1;

      case (state_q)
         S_RUN: begin
            elapsed_d = elapsed_q + 1'b1;
            win_cnt_d = win_cnt_q + 1'b1;
            if (stop || ((win_q != '0) && (win_cnt_q + 1'b1 == win_q))) state_d = S_DONE;
         end
         default: begin
            if (start) begin
               state_d   = S_RUN;
               win_d     = window_cycles;
               win_cnt_d = '0;
            end
         end
      endcase

      if (clear) begin
         state_d     = S_IDLE;
         win_cnt_d   = '0;
         elapsed_d   = '0;
         unmapped_d  = '0;
         open_d      = '0;
         first_run_d = '0;
         for (int i = 0; i < NUM_CH; i++) begin
            pkt_d[i]     = '0;
            beat_d[i]    = '0;
            byte_d[i]    = '0;
            min_len_d[i] = '1;
            max_len_d[i] = '0;
            cur_len_d[i] = '0;
         end
      end

      rd_pkt_d  = '0;
      rd_beat_d = '0;
      rd_byte_d = '0;
      rd_min_d  = '1;
      rd_max_d  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (32'(rd_ch) == i) begin
            rd_pkt_d  = pkt_q[i];
            rd_beat_d = beat_q[i];
            rd_byte_d = byte_q[i];
            rd_min_d  = min_len_q[i];
            rd_max_d  = max_len_q[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         win_q       <= '0;
         win_cnt_q   <= '0;
         elapsed_q   <= '0;
         unmapped_q  <= '0;
         open_q      <= '0;
         first_run_q <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            pkt_q[i]     <= '0;
            beat_q[i]    <= '0;
            byte_q[i]    <= '0;
            min_len_q[i] <= '1;
            max_len_q[i] <= '0;
            cur_len_q[i] <= '0;
         end
         rd_pkt_q  <= '0;
         rd_beat_q <= '0;
         rd_byte_q <= '0;
         rd_min_q  <= '1;
         rd_max_q  <= '0;
      end else begin
         state_q     <= state_d;
         win_q       <= win_d;
         win_cnt_q   <= win_cnt_d;
         elapsed_q   <= elapsed_d;
         unmapped_q  <= unmapped_d;
         open_q      <= open_d;
         first_run_q <= first_run_d;
         pkt_q       <= pkt_d;
         beat_q      <= beat_d;
         byte_q      <= byte_d;
         min_len_q   <= min_len_d;
         max_len_q   <= max_len_d;
         cur_len_q   <= cur_len_d;
         rd_pkt_q    <= rd_pkt_d;
         rd_beat_q   <= rd_beat_d;
         rd_byte_q   <= rd_byte_d;
         rd_min_q    <= rd_min_d;
         rd_max_q    <= rd_max_d;
      end
   end

   assign rd_pkt_cnt   = rd_pkt_q;
   assign rd_beat_cnt  = rd_beat_q;
   assign rd_byte_cnt  = rd_byte_q;
   assign rd_min_len   = rd_min_q;
   assign rd_max_len   = rd_max_q;
   assign unmapped_cnt = unmapped_q;
   assign elapsed_cnt  = elapsed_q;
   assign busy         = (state_q == S_RUN);
   assign done         = (state_q == S_DONE);

endmodule
